// File: rtl/sr_icache_pkg.sv
// Shared encodings and default geometry for the sr_cpu instruction cache.
package sr_icache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_LOOKUP = 2'd1,
    IC_FILL   = 2'd2
  } ic_state_t;

  localparam int          IC_AW       = 30;
  localparam int          IC_INDEX_W  = 4;
  localparam int          IC_OFFSET_W = 2;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;

endpackage

// File: rtl/sr_icache_mem.sv
// Tag/valid/data register arrays: combinational read, synchronous word and line writes.
module sr_icache_mem
  import sr_icache_pkg::*;
#(
  parameter int INDEX_W  = IC_INDEX_W,
  parameter int OFFSET_W = IC_OFFSET_W,
  parameter int TAG_W    = IC_AW - IC_INDEX_W - IC_OFFSET_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic [31:0]         rd_data_o,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_idx_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [31:0]         wr_data_i,
  input  logic                line_we_i,
  input  logic [TAG_W-1:0]    line_tag_i,
  input  logic                line_valid_i,
  input  logic                clr_all_i
);

  localparam int NLINES = 2 ** INDEX_W;
  localparam int NWORDS = 2 ** (INDEX_W + OFFSET_W);

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [31:0]       data_q [NWORDS];

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

  // Clear-all wins so a flush on the final refill beat leaves the line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid_q <= '0;
    else if (clr_all_i) valid_q <= '0;
    else if (line_we_i) valid_q[wr_idx_i] <= line_valid_i;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i)   data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    if (line_we_i) tag_q[wr_idx_i] <= line_tag_i;
  end

endmodule

// File: rtl/sr_icache.sv
// Direct-mapped read-only instruction cache for the sr_cpu fetch port.
//   state     | meaning
//   IC_IDLE   | no request outstanding
//   IC_LOOKUP | addr_q presented to arrays; hit answers this cycle
//   IC_FILL   | refilling line idx word by word from backing memory
module sr_icache
  import sr_icache_pkg::*;
#(
  parameter int          AW        = IC_AW,
  parameter int          INDEX_W   = IC_INDEX_W,
  parameter int          OFFSET_W  = IC_OFFSET_W,
  parameter logic [31:0] NOP_INSTR = RV_NOP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          im_req,
  input  logic [31:0]   imAddr,
  output logic [31:0]   imData,
  output logic          im_drdy,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rvalid
);

  localparam int TAG_W = AW - INDEX_W - OFFSET_W;

  ic_state_t           state_q;
  logic [AW-1:0]       addr_q;
  logic [OFFSET_W-1:0] beat_q;
  logic                flush_pend_q;
  logic                mem_req_q;

  logic [TAG_W-1:0]    tag, rd_tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic                rd_valid, hit, beat_done, last_beat;
  logic [31:0]         rd_data;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^imAddr[31:AW];

  assign tag = addr_q[AW-1:INDEX_W+OFFSET_W];
  assign idx = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign off = addr_q[OFFSET_W-1:0];

  assign hit       = (state_q == IC_LOOKUP) && rd_valid && (rd_tag == tag);
  assign im_drdy   = hit;
  assign imData    = hit ? rd_data : NOP_INSTR;
  assign beat_done = (state_q == IC_FILL) && mem_req_q && mem_rvalid;
  assign last_beat = beat_done && (beat_q == '1);
  assign mem_req   = mem_req_q;
  assign mem_addr  = {tag, idx, beat_q};

  sr_icache_mem #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W)
  ) u_mem (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx_i     (idx),
    .rd_off_i     (off),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .wr_en_i      (beat_done),
    .wr_idx_i     (idx),
    .wr_off_i     (beat_q),
    .wr_data_i    (mem_rdata),
    .line_we_i    (last_beat),
    .line_tag_i   (tag),
    .line_valid_i (~(flush_pend_q | flush)),
    .clr_all_i    (flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IC_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (im_req) begin
            addr_q  <= imAddr[AW-1:0];
            state_q <= IC_LOOKUP;
          end
        end
        IC_LOOKUP: begin
          if (hit) begin
            if (im_req) addr_q  <= imAddr[AW-1:0];
            else        state_q <= IC_IDLE;
          end else begin
            beat_q    <= '0;
            mem_req_q <= 1'b1;
            state_q   <= IC_FILL;
          end
        end
        IC_FILL: begin
          if (flush) flush_pend_q <= 1'b1;
          // Request drops for one cycle after each beat before the next word is asked for.
          if (beat_done) begin
            beat_q    <= beat_q + 1'b1;
            mem_req_q <= 1'b0;
            if (beat_q == '1) begin
              flush_pend_q <= 1'b0;
              state_q      <= IC_LOOKUP;
            end
          end else if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end
        end
        default: state_q <= IC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_icache.sv
// Scoreboard bench for sr_icache: directed fetches against a fixed-latency backing memory.
module tb_sr_icache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n, im_req, flush, mem_req, mem_rvalid, im_drdy;
  logic [31:0] imAddr, imData, mem_rdata;
  logic [29:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];
  logic [29:0] mem_exp[$];
  logic [31:0] chain_q[$];
  logic [29:0] stall_addr = '1;
  int          stall_extra = 0;

  sr_icache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_req     (im_req),
    .imAddr     (imAddr),
    .imData     (imData),
    .im_drdy    (im_drdy),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic exp_fill(input logic [29:0] base);
    for (int k = 0; k < 4; k++) mem_exp.push_back(base + 30'(k));
  endtask

  task automatic exp_resp(input logic [29:0] a);
    sb_q.push_back(32'h1000_0000 + {2'b00, a});
  endtask

  // Response monitor: every drdy pops one expected word; otherwise the bus must idle at NOP.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (im_drdy) begin
          chk(sb_q.size() > 0, "resp_expected", 32'(sb_q.size()), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(imData == e, "resp_data", imData, e);
          end
        end else begin
          chk(imData == NOP, "nop_when_idle", imData, NOP);
        end
      end
    end
  end

  // Backing memory: one-cycle wait then a single rvalid strobe; optional long stall on one address.
  initial begin
    logic [29:0] a, e;
    bit          has, aborted;
    int          waits;
    mem_rvalid = 0;
    mem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        a   = mem_addr;
        has = mem_exp.size() > 0;
        chk(has, "mem_req_expected", {2'b00, a}, 32'd0);
        if (has) begin
          e = mem_exp.pop_front();
          chk(a == e, "mem_addr_seq", {2'b00, a}, {2'b00, e});
        end
        waits   = (a == stall_addr) ? 1 + stall_extra : 1;
        aborted = 0;
        for (int k = 0; k < waits; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1;
            break;
          end
          chk(mem_req && (mem_addr == a), "mem_req_hold", {1'b0, mem_req, mem_addr}, {2'b01, a});
        end
        if (!aborted) begin
          mem_rdata  = 32'h1000_0000 + {2'b00, a};
          mem_rvalid = 1;
          @(negedge clk);
          mem_rvalid = 0;
          mem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic wait_drdy();
    int c = 0;
    while (!im_drdy && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(im_drdy, "drdy_timeout", {31'd0, im_drdy}, 32'd1);
  endtask

  // Issues chain_q in order, each subsequent request on the previous response cycle.
  task automatic run_chain(input bit hits);
    int n = chain_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) wait_drdy();
      im_req = 1;
      imAddr = chain_q.pop_front();
      @(posedge clk);
      #1;
      im_req = 0;
      imAddr = 32'h0;
      if (hits) chk(im_drdy, "hit_latency", {31'd0, im_drdy}, 32'd1);
    end
    wait_drdy();
    @(posedge clk);
    #1;
    chk(mem_exp.size() == 0, "mem_seq_done", 32'(mem_exp.size()), 32'd0);
    chk(sb_q.size() == 0, "resp_all_seen", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 0; im_req = 0; imAddr = 0; flush = 0;
    #15;
    chk(!im_drdy, "rst_drdy", {31'd0, im_drdy}, 32'd0);
    chk(imData == NOP, "rst_imdata", imData, NOP);
    chk(!mem_req, "rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk(mem_addr == 30'd0, "rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    @(posedge clk); #3; rst_n = 1;
    @(posedge clk); #1;

    // Cold miss on word 0
    exp_fill(30'h0); exp_resp(30'h0);
    chain_q.push_back(32'h0);
    run_chain(0);

    // Back-to-back hits in the freshly filled line
    exp_resp(30'h1); exp_resp(30'h2); exp_resp(30'h3);
    chain_q.push_back(32'h1); chain_q.push_back(32'h2); chain_q.push_back(32'h3);
    run_chain(1);

    // Conflict: 0x40 shares index 0 with 0x00
    exp_fill(30'h40); exp_resp(30'h40);
    chain_q.push_back(32'h40);
    run_chain(0);
    exp_fill(30'h0); exp_resp(30'h0);
    chain_q.push_back(32'h0);
    run_chain(0);

    // Flush while idle invalidates the line
    pulse_flush();
    exp_fill(30'h0); exp_resp(30'h0);
    chain_q.push_back(32'h0);
    run_chain(0);

    // Flush during a fill forces a second full refill
    exp_fill(30'h10); exp_fill(30'h10); exp_resp(30'h10);
    chain_q.push_back(32'h10);
    fork
      run_chain(0);
      begin
        c = 0;
        while (!(mem_req && mem_addr == 30'h11) && c < 300) begin
          @(posedge clk); #1; c++;
        end
        chk(c < 300, "flush_trigger", 32'(c), 32'd300);
        pulse_flush();
      end
    join

    // Long stall on beat 2
    stall_addr = 30'h22; stall_extra = 20;
    exp_fill(30'h20); exp_resp(30'h22);
    chain_q.push_back(32'h22);
    run_chain(0);
    stall_addr = '1; stall_extra = 0;

    // Reset during beat 1 abandons the fill
    mem_exp.push_back(30'h30); mem_exp.push_back(30'h31);
    im_req = 1; imAddr = 32'h30;
    @(posedge clk); #1;
    im_req = 0; imAddr = 0;
    c = 0;
    while (!(mem_req && mem_addr == 30'h31) && c < 300) begin
      @(posedge clk); #1; c++;
    end
    chk(c < 300, "rst_trigger", 32'(c), 32'd300);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk(!mem_req, "rst_fill_mem_req", {31'd0, mem_req}, 32'd0);
    chk(!im_drdy, "rst_fill_drdy", {31'd0, im_drdy}, 32'd0);
    chk(mem_addr == 30'd0, "rst_fill_mem_addr", {2'b00, mem_addr}, 32'd0);
    repeat (3) @(posedge clk);
    #3; rst_n = 1;
    @(posedge clk); #1;
    chk(mem_exp.size() == 0, "rst_fill_beats", 32'(mem_exp.size()), 32'd0);
    exp_fill(30'h30); exp_resp(30'h30);
    chain_q.push_back(32'h30);
    run_chain(0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
